// File: rtl/arb_pkg.sv
// Shared state encoding and counter width for the round-robin arbiter.
package arb_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = IDLE,
      S_BUSY = BUSY,
      S_GAP  = GAP
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority search: first set req bit at or above ptr, wrapping.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [N-1:0]  rot;
   logic [IW-1:0] cand [N];

   // rot[k] is the request that sits k places above the pointer.
   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign cand[gi] = IW'((int'(ptr) + gi) % N);
      assign rot[gi]  = req[cand[gi]];
   end

   always_comb begin
      found = |rot;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            idx = cand[k];
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded hold time and a mandatory idle cycle between owners.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16,
   parameter int IW       = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_id,
   output logic          busy,
   output logic          timeout
);

   arb_state_e       state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [IW-1:0]    gnt_id_q, gnt_id_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;

   logic             pick_found;
   logic [IW-1:0]    pick_idx;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;

      case (state_q)
         S_BUSY: begin
            if (req[gnt_id_q] && (cnt_q < CNT_W'(MAX_HOLD))) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               // A still-requesting owner here has run out its hold budget.
               state_d   = S_GAP;
               gnt_d     = '0;
               gnt_id_d  = '0;
               busy_d    = 1'b0;
               cnt_d     = '0;
               timeout_d = req[gnt_id_q];
            end
         end
         default: begin
            if (pick_found) begin
               state_d  = S_BUSY;
               gnt_d    = N'(1) << pick_idx;
               gnt_id_d = pick_idx;
               busy_d   = 1'b1;
               cnt_d    = CNT_W'(1);
               ptr_d    = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
            end else begin
               state_d  = S_IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
               cnt_d    = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule
